// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Build option: define IFU_ALIGN_CHECK_EN to trap misaligned redirect targets.
package ifu_pkg;

    // Fetch control states: RUN fetches normally, HALT stops fetching until reset
    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } ifu_state_e;

    // Byte distance between consecutive 32-bit instructions
    localparam logic [31:0] PC_INC = 32'd4;

    // First fetch address after reset unless the top overrides it
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ifu_fifo.sv
// Small circular instruction buffer with push/pop/flush and occupancy count.
// Head entry is read straight from storage registers, so there is no
// combinational path from the write data to the head output.
module ifu_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

    // Pointer, storage and count update; flush wins, pointers wrap naturally
    // because DEPTH is a power of two
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Buffer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: walks fetch_pc through a combinational-read
// instruction memory and queues {pc, instr} pairs for the decode stage.
// Build option: define IFU_ALIGN_CHECK_EN to fault and halt on a misaligned
// redirect target; otherwise the low two target bits are dropped.
module instruction_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fault
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    ifu_state_e        state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic              fault_q, fault_d;
    logic              push;
    logic              pop;
    logic              flush;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [63:0]       head_data;
    logic [31:0]       redirect_target;
    logic              misaligned;

`ifdef IFU_ALIGN_CHECK_EN
    assign misaligned      = (redirect_pc[1:0] != 2'b00);
    assign redirect_target = redirect_pc;
`else
    assign misaligned      = 1'b0;
    assign redirect_target = redirect_pc & ~32'h3;
`endif

    assign imem_addr = fetch_pc_q;
    assign out_valid = (fifo_count != '0);
    assign out_pc    = head_data[63:32];
    assign out_instr = head_data[31:0];
    assign fault     = fault_q;

    ifu_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({fetch_pc_q, imem_rdata}),
        .pop       (pop),
        .flush     (flush),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Next state: redirect flushes and overrides any handshake, otherwise
    // fetch whenever a slot is free (including one freed by this cycle's pop)
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        fault_d    = fault_q;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        if (redirect_valid) begin
            flush = 1'b1;
            if (misaligned) begin
                fault_d = 1'b1;
                state_d = HALT;
            end else if (state_q == RUN) begin
                fetch_pc_d = redirect_target;
            end
        end else begin
            pop = !fifo_empty && out_ready;
            if ((state_q == RUN) && (!fifo_full || pop)) begin
                push       = 1'b1;
                fetch_pc_d = fetch_pc_q + PC_INC;
            end
        end
    end

    // Fetch control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            fault_q    <= fault_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed phases push the
// hand-computed {pc, instr} handshakes into a queue and a negedge monitor
// pops and compares each accepted head entry.
module tb_instruction_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } expEntry_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fault;

    int          checkCount;
    int          errorCount;
    expEntry_t   expQ[$];
    expEntry_t   monEntry;

    instruction_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fault          (fault)
    );

    // Memory model: word i holds the value i
    assign imem_rdata = imem_addr >> 2;

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: a handshake completes at the next rising edge
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !redirect_valid) begin
            checkCount++;
            if (expQ.size() == 0) begin
                errorCount++;
                $display("[TB] FAIL sb_unexpected: got pc=%h instr=%h, required no handshake", out_pc, out_instr);
            end else begin
                monEntry = expQ.pop_front();
                if (out_pc !== monEntry.pc || out_instr !== monEntry.instr) begin
                    errorCount++;
                    $display("[TB] FAIL sb_head: got pc=%h instr=%h, required pc=%h instr=%h",
                             out_pc, out_instr, monEntry.pc, monEntry.instr);
                end
            end
        end
    end

    // Watchdog so a stuck run still terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic pushExp(input logic [31:0] pc, input logic [31:0] instr);
        expEntry_t e;
        e.pc    = pc;
        e.instr = instr;
        expQ.push_back(e);
    endtask

    // Redirect from a posedge+1 point, check the flush bubble, then allow
    // numHs handshakes before dropping out_ready again
    task automatic applyStimulus(input logic [31:0] target, input logic [31:0] expAddr, input int numHs);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        out_ready      = 1'b1;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        checkOutput("redir_bubble_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("redir_fetch_addr", imem_addr, expAddr);
        repeat (numHs + 1) @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        checkCount     = 0;
        errorCount     = 0;
        rst_n          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Reset state
        @(negedge clk);
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_imem_addr", imem_addr, 32'h0);
        checkOutput("rst_out_pc", out_pc, 32'h0);
        checkOutput("rst_out_instr", out_instr, 32'h0);
        checkOutput("rst_fault", {31'b0, fault}, 32'd0);

        // Streaming from reset with decode always ready
        pushExp(32'h0, 32'h0);
        pushExp(32'h4, 32'h1);
        pushExp(32'h8, 32'h2);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("full_hold_addr", imem_addr, 32'h14);
        checkOutput("full_head_pc", out_pc, 32'hC);

        // Asynchronous reset while full
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("async_rst_addr", imem_addr, 32'h0);
        checkOutput("async_rst_pc", out_pc, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("restart_addr", imem_addr, 32'h0);
        checkOutput("restart_valid", {31'b0, out_valid}, 32'd0);

        // Back-pressure: buffer saturates and fetch holds
        repeat (2) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("stall_addr", imem_addr, 32'h8);
            checkOutput("stall_pc", out_pc, 32'h0);
        end

        // Redirect to 0x40 while full
        pushExp(32'h40, 32'h10);
        pushExp(32'h44, 32'h11);
        @(posedge clk);
        #1;
        applyStimulus(32'h40, 32'h40, 2);

        // Redirect to the top word; fetch wraps to zero
        pushExp(32'hFFFF_FFFC, 32'h3FFF_FFFF);
        pushExp(32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(32'hFFFF_FFFC, 32'hFFFF_FFFC, 2);

        // Misaligned redirect target
        repeat (2) @(posedge clk);
        #1;
`ifdef IFU_ALIGN_CHECK_EN
        applyStimulus(32'h42, 32'hC, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("halt_fault", {31'b0, fault}, 32'd1);
            checkOutput("halt_valid", {31'b0, out_valid}, 32'd0);
            checkOutput("halt_addr", imem_addr, 32'hC);
        end
        out_ready = 1'b0;
`else
        pushExp(32'h40, 32'h10);
        pushExp(32'h44, 32'h11);
        applyStimulus(32'h42, 32'h40, 2);
        @(negedge clk);
        checkOutput("no_fault", {31'b0, fault}, 32'd0);
`endif

        repeat (3) @(negedge clk);
        checkOutput("sb_drain", expQ.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
